// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: the CPU wins by default,
// and the external port is force-granted after STARVE_LIMIT consecutive denied cycles.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    // CPU port
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [9:0]  cpu_addr_i,
    input  logic [3:0]  cpu_mask_i,
    input  logic [31:0] cpu_wdata_i,
    output logic        cpu_stall_o,
    output logic        cpu_rvalid_o,
    output logic [31:0] cpu_rdata_o,
    // external port
    input  logic        ext_valid_i,
    output logic        ext_ready_o,
    input  logic        ext_we_i,
    input  logic [9:0]  ext_addr_i,
    input  logic [3:0]  ext_mask_i,
    input  logic [31:0] ext_wdata_i,
    output logic        ext_rvalid_o,
    output logic [31:0] ext_rdata_o,
    // memory side
    output logic        mem_ceb_o,
    output logic        mem_web_o,
    output logic [9:0]  mem_a_o,
    output logic [3:0]  mem_mask_o,
    output logic [31:0] mem_d_o,
    input  logic [31:0] mem_q_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    owner_e     owner_q, owner_d;

    logic forced;
    logic grant_cpu;
    logic grant_ext;

    // Requests are ignored while reset is high, so no grant can leak into the reset cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        forced    = 1'b0;
        grant_cpu = 1'b0;
        grant_ext = 1'b0;
        if (!reset) begin
            forced    = ext_valid_i && (starve_q == LIMIT);
            grant_cpu = cpu_req_i && !forced;
            grant_ext = ext_valid_i && !grant_cpu;
        end
    end

    always_comb begin
        starve_d = 4'd0;
        owner_d  = OWN_NONE;
        if (!reset) begin
            if (ext_valid_i && !grant_ext) begin
                starve_d = starve_q + 4'd1;
            end
            if (grant_cpu && !cpu_we_i) begin
                owner_d = OWN_CPU;
            end else if (grant_ext && !ext_we_i) begin
                owner_d = OWN_EXT;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        starve_q <= starve_d;
        owner_q  <= owner_d;
    end

    always_comb begin
        mem_ceb_o  = 1'b1;
        mem_web_o  = 1'b1;
        mem_a_o    = 10'd0;
        mem_mask_o = 4'd0;
        mem_d_o    = 32'd0;
        if (grant_cpu) begin
            mem_ceb_o  = 1'b0;
            mem_web_o  = ~cpu_we_i;
            mem_a_o    = cpu_addr_i;
            mem_mask_o = cpu_mask_i;
            mem_d_o    = cpu_wdata_i;
        end else if (grant_ext) begin
            mem_ceb_o  = 1'b0;
            mem_web_o  = ~ext_we_i;
            mem_a_o    = ext_addr_i;
            mem_mask_o = ext_mask_i;
            mem_d_o    = ext_wdata_i;
        end
    end

    // A read in flight when reset rises is dropped, even though owner_q still holds it.
    always_comb begin
        cpu_rvalid_o = !reset && (owner_q == OWN_CPU);
        ext_rvalid_o = !reset && (owner_q == OWN_EXT);
        cpu_rdata_o  = cpu_rvalid_o ? mem_q_i : 32'd0;
        ext_rdata_o  = ext_rvalid_o ? mem_q_i : 32'd0;
    end

    assign cpu_stall_o = !reset && cpu_req_i && !grant_cpu;
    assign ext_ready_o = grant_ext;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-masked 1-cycle-latency memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req_i, cpu_we_i;
    logic [9:0]  cpu_addr_i;
    logic [3:0]  cpu_mask_i;
    logic [31:0] cpu_wdata_i;
    logic        cpu_stall_o, cpu_rvalid_o;
    logic [31:0] cpu_rdata_o;
    logic        ext_valid_i, ext_ready_o, ext_we_i;
    logic [9:0]  ext_addr_i;
    logic [3:0]  ext_mask_i;
    logic [31:0] ext_wdata_i;
    logic        ext_rvalid_o;
    logic [31:0] ext_rdata_o;
    logic        mem_ceb_o, mem_web_o;
    logic [9:0]  mem_a_o;
    logic [3:0]  mem_mask_o;
    logic [31:0] mem_d_o;
    logic [31:0] mem_q_i;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_mask_i(cpu_mask_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_stall_o(cpu_stall_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .ext_valid_i(ext_valid_i), .ext_ready_o(ext_ready_o), .ext_we_i(ext_we_i),
        .ext_addr_i(ext_addr_i), .ext_mask_i(ext_mask_i), .ext_wdata_i(ext_wdata_i),
        .ext_rvalid_o(ext_rvalid_o), .ext_rdata_o(ext_rdata_o),
        .mem_ceb_o(mem_ceb_o), .mem_web_o(mem_web_o), .mem_a_o(mem_a_o),
        .mem_mask_o(mem_mask_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q_i)
    );

    logic [31:0] mem [1024];

    always @(posedge clk) begin
        if (!mem_ceb_o) begin
            if (!mem_web_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_mask_o[b]) mem[mem_a_o][8*b +: 8] <= mem_d_o[8*b +: 8];
                end
            end else begin
                mem_q_i <= mem[mem_a_o];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies inputs 1 ns after a rising edge, then waits so checks land mid-cycle.
    task automatic drv(input logic c_req, input logic c_we, input logic [9:0] c_a,
                       input logic [3:0] c_m, input logic [31:0] c_d,
                       input logic e_val, input logic e_we, input logic [9:0] e_a,
                       input logic [3:0] e_m, input logic [31:0] e_d);
        @(posedge clk);
        #1;
        cpu_req_i = c_req; cpu_we_i = c_we; cpu_addr_i = c_a; cpu_mask_i = c_m; cpu_wdata_i = c_d;
        ext_valid_i = e_val; ext_we_i = e_we; ext_addr_i = e_a; ext_mask_i = e_m; ext_wdata_i = e_d;
        #3;
    endtask

    task automatic idle();
        drv(0, 0, 10'h0, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
    endtask

    task automatic contend();
        drv(1, 0, 10'h001, 4'hF, 32'h0, 1, 0, 10'h002, 4'hF, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_mask_i = 0; cpu_wdata_i = 0;
        ext_valid_i = 0; ext_we_i = 0; ext_addr_i = 0; ext_mask_i = 0; ext_wdata_i = 0;

        // Reset with both ports requesting: everything ignored.
        drv(1, 0, 10'h010, 4'hF, 32'h0, 1, 1, 10'h010, 4'hF, 32'h1);
        check("rst_stall", 32'(cpu_stall_o), 32'd0);
        check("rst_ready", 32'(ext_ready_o), 32'd0);
        check("rst_ceb", 32'(mem_ceb_o), 32'd1);
        check("rst_crv", 32'(cpu_rvalid_o), 32'd0);
        check("rst_erv", 32'(ext_rvalid_o), 32'd0);
        drv(1, 0, 10'h010, 4'hF, 32'h0, 1, 1, 10'h010, 4'hF, 32'h1);
        reset = 1'b0;

        // Preload through the external port.
        drv(0, 0, 10'h0, 4'h0, 32'h0, 1, 1, 10'h010, 4'hF, 32'hDEADBEEF);
        check("pre_ready", 32'(ext_ready_o), 32'd1);
        check("pre_web", 32'(mem_web_o), 32'd0);
        check("pre_a", 32'(mem_a_o), 32'h010);
        check("pre_d", mem_d_o, 32'hDEADBEEF);
        drv(0, 0, 10'h0, 4'h0, 32'h0, 1, 1, 10'h001, 4'hF, 32'h11111111);
        drv(0, 0, 10'h0, 4'h0, 32'h0, 1, 1, 10'h002, 4'hF, 32'h22222222);
        drv(0, 0, 10'h0, 4'h0, 32'h0, 1, 1, 10'h3FF, 4'hF, 32'h00000000);
        idle();
        check("wr_no_rvalid", 32'(ext_rvalid_o), 32'd0);
        check("idle_ceb", 32'(mem_ceb_o), 32'd1);
        check("idle_a", 32'(mem_a_o), 32'd0);

        // CPU-only load.
        drv(1, 0, 10'h010, 4'hF, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
        check("ld_stall", 32'(cpu_stall_o), 32'd0);
        check("ld_ceb", 32'(mem_ceb_o), 32'd0);
        check("ld_web", 32'(mem_web_o), 32'd1);
        check("ld_a", 32'(mem_a_o), 32'h010);
        idle();
        check("ld_crv", 32'(cpu_rvalid_o), 32'd1);
        check("ld_rdata", cpu_rdata_o, 32'hDEADBEEF);
        check("ld_erv", 32'(ext_rvalid_o), 32'd0);
        check("ld_erdata", ext_rdata_o, 32'd0);
        idle();
        check("ld_crv_off", 32'(cpu_rvalid_o), 32'd0);
        check("ld_rdata_off", cpu_rdata_o, 32'd0);

        // CPU masked store wins against an external read, which follows next cycle.
        drv(1, 1, 10'h3FF, 4'b0100, 32'h00AB0000, 1, 0, 10'h3FF, 4'hF, 32'h0);
        check("st_ready", 32'(ext_ready_o), 32'd0);
        check("st_stall", 32'(cpu_stall_o), 32'd0);
        check("st_web", 32'(mem_web_o), 32'd0);
        check("st_mask", 32'(mem_mask_o), 32'h4);
        check("st_d", mem_d_o, 32'h00AB0000);
        check("st_a", 32'(mem_a_o), 32'h3FF);
        drv(0, 0, 10'h0, 4'h0, 32'h0, 1, 0, 10'h3FF, 4'hF, 32'h0);
        check("st_ready2", 32'(ext_ready_o), 32'd1);
        check("st_web2", 32'(mem_web_o), 32'd1);
        idle();
        check("st_erv", 32'(ext_rvalid_o), 32'd1);
        check("st_erdata", ext_rdata_o, 32'h00AB0000);

        // Continuous contention: forced grant on the 5th and 10th cycles.
        for (int i = 0; i < 10; i++) begin
            contend();
            check($sformatf("starve_ready_%0d", i), 32'(ext_ready_o), 32'(i == 4 || i == 9));
            check($sformatf("starve_stall_%0d", i), 32'(cpu_stall_o), 32'(i == 4 || i == 9));
            if (i == 5) begin
                check("starve_erv", 32'(ext_rvalid_o), 32'd1);
                check("starve_erdata", ext_rdata_o, 32'h22222222);
                check("starve_crv", 32'(cpu_rvalid_o), 32'd0);
            end else if (i > 0) begin
                check($sformatf("starve_crdata_%0d", i), cpu_rdata_o, 32'h11111111);
            end
        end
        idle();
        check("starve_tail_erv", 32'(ext_rvalid_o), 32'd1);

        // Cancel: ext_valid drops without a grant and the counter restarts.
        repeat (3) contend();
        idle();
        check("cancel_ceb", 32'(mem_ceb_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            contend();
            check($sformatf("cancel_ready_%0d", i), 32'(ext_ready_o), 32'(i == 4));
        end
        idle();

        // Alternating owners on back-to-back reads.
        drv(1, 0, 10'h001, 4'hF, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
        drv(0, 0, 10'h0, 4'h0, 32'h0, 1, 0, 10'h002, 4'hF, 32'h0);
        check("alt_ready", 32'(ext_ready_o), 32'd1);
        check("alt_crv", 32'(cpu_rvalid_o), 32'd1);
        check("alt_crdata", cpu_rdata_o, 32'h11111111);
        idle();
        check("alt_erv", 32'(ext_rvalid_o), 32'd1);
        check("alt_erdata", ext_rdata_o, 32'h22222222);
        check("alt_crv_off", 32'(cpu_rvalid_o), 32'd0);

        // Reset right after a granted external read drops the return.
        drv(0, 0, 10'h0, 4'h0, 32'h0, 1, 0, 10'h010, 4'hF, 32'h0);
        check("rr_ready", 32'(ext_ready_o), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        cpu_req_i = 1'b1; ext_valid_i = 1'b0;
        #3;
        check("rr_erv", 32'(ext_rvalid_o), 32'd0);
        check("rr_ceb", 32'(mem_ceb_o), 32'd1);
        check("rr_stall", 32'(cpu_stall_o), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        check("rr_erv_after", 32'(ext_rvalid_o), 32'd0);
        drv(1, 0, 10'h002, 4'hF, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
        check("rr_resume_ceb", 32'(mem_ceb_o), 32'd0);
        idle();
        check("rr_resume_crdata", cpu_rdata_o, 32'h22222222);

        // Reset clears a partially built starve count.
        repeat (3) contend();
        @(posedge clk);
        #1 reset = 1'b1;
        #3;
        check("rc_ready", 32'(ext_ready_o), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        #3;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) contend();
            check($sformatf("rc_ready_%0d", i), 32'(ext_ready_o), 32'(i == 4));
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
